rv32_decode_exec: RTL and testbench

- Single-cycle RV32I decode/execute slice: instruction decoder, 32-bit ALU, load-data extender, branch resolution, next-PC selection and one registered write-back stage.
- Sits between the PC/instruction memory and the register file/data memory of the core.
- Register file and PC register are external.

---
 rtl/rv32_decode_exec.sv | 208 ++++++++++++++++++++
 tb/tb_rv32_decode_exec.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_exec.sv
// RV32I decode/execute slice: decoder, ALU, load extender, branch/next-PC logic and a registered write-back stage.
// Optional macro ILLEGAL_DET_EN adds a registered illegal-opcode flag (illegal_q).
module rv32_decode_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] load_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_mode,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] wb_data_q,
    output logic [4:0]      wb_rd_q,
    output logic            wb_en_q
`ifdef ILLEGAL_DET_EN
    ,
    output logic            illegal_q
`endif
);

    localparam int unsigned SHW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            is_op, is_opimm, is_load, is_store, is_branch;
    logic            is_jalr, is_jal, is_auipc, is_lui, illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1, op2;
    logic [2:0]      uop;
    logic            sub_bit;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] alu_out;
    logic            zero;
    logic            taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rd       = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OP_IMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_lui    = (opcode == OPC_LUI);
    assign illegal   = ~(is_op | is_opimm | is_load | is_store | is_branch |
                         is_jalr | is_jal | is_auipc | is_lui);

    // Immediate formats, all sign-extended from instr[31]
    always_comb begin
        imm = '0;
        if (is_opimm || is_load || is_jalr)
            imm = {{20{instr[31]}}, instr[31:20]};
        else if (is_store)
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_branch)
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_auipc || is_lui)
            imm = {instr[31:12], 12'b0};
        else if (is_jal)
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    assign op1 = is_auipc ? pc : rs1_data;
    assign op2 = (is_opimm || is_load || is_store || is_jalr || is_auipc) ? imm : rs2_data;

    // ALU micro-op and subtract/arithmetic-shift select
    always_comb begin
        uop     = 3'b000;
        sub_bit = 1'b0;
        if (is_op) begin
            uop     = funct3;
            sub_bit = instr[30];
        end else if (is_opimm) begin
            uop     = funct3;
            sub_bit = (funct3 == 3'b101) & instr[30];
        end else if (is_branch) begin
            case (funct3[2:1])
                2'b10:   uop = 3'b010;
                2'b11:   uop = 3'b011;
                default: begin
                    uop     = 3'b000;
                    sub_bit = 1'b1;
                end
            endcase
        end
    end

    assign shamt   = op2[SHW-1:0];
    assign sra_res = $signed(op1) >>> shamt;

    always_comb begin
        alu_out = '0;
        case (uop)
            3'b000:  alu_out = sub_bit ? (op1 - op2) : (op1 + op2);
            3'b001:  alu_out = op1 << shamt;
            3'b010:  alu_out = XLEN'($signed(op1) < $signed(op2));
            3'b011:  alu_out = XLEN'(op1 < op2);
            3'b100:  alu_out = op1 ^ op2;
            3'b101:  alu_out = sub_bit ? sra_res : (op1 >> shamt);
            3'b110:  alu_out = op1 | op2;
            default: alu_out = op1 & op2;
        endcase
    end

    assign zero     = (alu_out == '0);
    assign taken    = is_branch & ((funct3[2] ^ funct3[0]) ? ~zero : zero);
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        next_pc = pc_plus4;
        if (is_jal || taken)
            next_pc = pc + imm;
        else if (is_jalr)
            next_pc = {alu_out[XLEN-1:1], 1'b0};
    end

    assign mem_addr  = alu_out;
    assign mem_wdata = rs2_data;

    always_comb begin
        mem_mode = 2'b00;
        if (is_store) begin
            case (funct3)
                3'b000:  mem_mode = 2'b01;
                3'b001:  mem_mode = 2'b10;
                3'b010:  mem_mode = 2'b11;
                default: mem_mode = 2'b00;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  load_ext = {{24{load_data[7]}}, load_data[7:0]};
            3'b001:  load_ext = {{16{load_data[15]}}, load_data[15:0]};
            3'b100:  load_ext = {24'b0, load_data[7:0]};
            3'b101:  load_ext = {16'b0, load_data[15:0]};
            default: load_ext = load_data;
        endcase
    end

    always_comb begin
        wb_data = alu_out;
        if (is_load)
            wb_data = load_ext;
        else if (is_lui)
            wb_data = imm;
        else if (is_jal || is_jalr)
            wb_data = pc_plus4;
    end

    assign wb_en = ~illegal & ~is_store & ~is_branch & (rd != 5'd0);

    // Write-back register: stall holds data/rd and suppresses the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_en_q   <= 1'b0;
        end else if (stall) begin
            wb_en_q   <= 1'b0;
        end else begin
            wb_data_q <= wb_data;
            wb_rd_q   <= rd;
            wb_en_q   <= wb_en;
        end
    end

`ifdef ILLEGAL_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_q <= 1'b0;
        else
            illegal_q <= stall ? 1'b0 : illegal;
    end
`endif

endmodule

// File: tb/tb_rv32_decode_exec.sv
// Directed self-checking bench for rv32_decode_exec with hand-computed expected values.
module tb_rv32_decode_exec;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] load_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_mode;
    logic [31:0] next_pc;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_en_q;
`ifdef ILLEGAL_DET_EN
    logic        illegal_q;
`endif

    int checks;
    int failures;

    rv32_decode_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .load_data (load_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mode  (mem_mode),
        .next_pc   (next_pc),
        .wb_data_q (wb_data_q),
        .wb_rd_q   (wb_rd_q),
        .wb_en_q   (wb_en_q)
`ifdef ILLEGAL_DET_EN
        ,
        .illegal_q (illegal_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Apply an instruction and its operands, then let the combinational outputs settle
    task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ld);
        instr     = i;
        pc        = p;
        rs1_data  = a;
        rs2_data  = b;
        load_data = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        instr     = 32'h0000_0013;
        pc        = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        load_data = 32'h0;
        tick();
        tick();
        check("reset_wb_data", wb_data_q, 32'h0);
        check("reset_wb_rd", 32'(wb_rd_q), 32'h0);
        check("reset_wb_en", 32'(wb_en_q), 32'h0);
        rst = 1'b0;

        // lui x5,0x12345 loads non-zero write-back state
        apply(32'h1234_52B7, 32'h40, 32'h0, 32'h0, 32'h0);
        tick();
        check("lui_data", wb_data_q, 32'h1234_5000);
        check("lui_rd", 32'(wb_rd_q), 32'd5);
        check("lui_en", 32'(wb_en_q), 32'd1);

        // Asynchronous reset in mid-cycle clears write-back immediately
        #2;
        rst = 1'b1;
        #1;
        check("midrst_data", wb_data_q, 32'h0);
        check("midrst_rd", 32'(wb_rd_q), 32'h0);
        check("midrst_en", 32'(wb_en_q), 32'h0);
        rst = 1'b0;

        apply(32'h0020_81B3, 32'h40, 32'd5, 32'd7, 32'h0);
        check("add_rs1_addr", 32'(rs1_addr), 32'd1);
        check("add_rs2_addr", 32'(rs2_addr), 32'd2);
        check("add_next_pc", next_pc, 32'h44);
        tick();
        check("add_data", wb_data_q, 32'd12);
        check("add_rd", 32'(wb_rd_q), 32'd3);
        check("add_en", 32'(wb_en_q), 32'd1);

        apply(32'h4020_81B3, 32'h40, 32'd5, 32'd7, 32'h0);
        tick();
        check("sub_data", wb_data_q, 32'hFFFF_FFFE);

        apply(32'h4040_D193, 32'h40, 32'h8000_0000, 32'h0, 32'h0);
        tick();
        check("srai_data", wb_data_q, 32'hF800_0000);

        apply(32'h4000_8193, 32'h40, 32'd1, 32'h0, 32'h0);
        tick();
        check("addi_f7_data", wb_data_q, 32'h0000_0401);

        apply(32'h0000_8183, 32'h40, 32'h0, 32'h0, 32'h0000_00F0);
        tick();
        check("lb_data", wb_data_q, 32'hFFFF_FFF0);

        apply(32'h0000_C183, 32'h40, 32'h0, 32'h0, 32'h0000_00F0);
        tick();
        check("lbu_data", wb_data_q, 32'h0000_00F0);

        apply(32'h0020_9223, 32'h40, 32'h100, 32'hCAFE_BEEF, 32'h0);
        check("sh_addr", mem_addr, 32'h104);
        check("sh_mode", 32'(mem_mode), 32'h2);
        check("sh_wdata", mem_wdata, 32'hCAFE_BEEF);
        tick();
        check("sh_en", 32'(wb_en_q), 32'd0);

        apply(32'h0020_8463, 32'h40, 32'd9, 32'd9, 32'h0);
        check("beq_taken", next_pc, 32'h48);
        check("beq_mode", 32'(mem_mode), 32'h0);
        apply(32'h0020_8463, 32'h40, 32'd9, 32'd8, 32'h0);
        check("beq_not_taken", next_pc, 32'h44);
        apply(32'h0020_C463, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("blt_taken", next_pc, 32'h48);
        apply(32'h0020_E463, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("bltu_not_taken", next_pc, 32'h44);
        tick();
        check("branch_en", 32'(wb_en_q), 32'd0);

        apply(32'h0100_00EF, 32'h40, 32'h0, 32'h0, 32'h0);
        check("jal_next_pc", next_pc, 32'h50);
        tick();
        check("jal_data", wb_data_q, 32'h44);
        check("jal_rd", 32'(wb_rd_q), 32'd1);

        apply(32'h0031_00E7, 32'h40, 32'h100, 32'h0, 32'h0);
        check("jalr_rs1_addr", 32'(rs1_addr), 32'd2);
        check("jalr_next_pc", next_pc, 32'h102);
        tick();
        check("jalr_data", wb_data_q, 32'h44);

        apply(32'h1234_5297, 32'h40, 32'h0, 32'h0, 32'h0);
        tick();
        check("auipc_data", wb_data_q, 32'h1234_5040);

        // Stall holds data and forces the enable low
        apply(32'h0020_81B3, 32'h40, 32'd5, 32'd7, 32'h0);
        stall = 1'b1;
        tick();
        check("stall_en", 32'(wb_en_q), 32'd0);
        check("stall_data", wb_data_q, 32'h1234_5040);
        check("stall_rd", 32'(wb_rd_q), 32'd5);
        stall = 1'b0;
        tick();
        check("unstall_data", wb_data_q, 32'd12);
        check("unstall_en", 32'(wb_en_q), 32'd1);

        apply(32'h0000_007F, 32'h80, 32'd1, 32'd2, 32'h0);
        check("illegal_next_pc", next_pc, 32'h84);
        check("illegal_mode", 32'(mem_mode), 32'h0);
        tick();
        check("illegal_en", 32'(wb_en_q), 32'd0);
`ifdef ILLEGAL_DET_EN
        check("illegal_flag", 32'(illegal_q), 32'd1);
        stall = 1'b1;
        tick();
        check("illegal_flag_stall", 32'(illegal_q), 32'd0);
        stall = 1'b0;
`endif

        // Next-PC wraps modulo 2^32
        apply(32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
        check("wrap_next_pc", next_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
